// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory request path.
// Size encodings match the req_size field; state enum is shared with the bench for debug.
package mem_pkg;

  localparam int WORD_IDX_BITS_DEF = 10;
  localparam int MEM_WORDS = 2 ** WORD_IDX_BITS_DEF;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for a word-only memory: extract+extend for loads,
// read-modify-write merge for sub-word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted   = word >> {addr_lo, 3'b000};
    lane_b    = shifted[7:0];
    lane_h    = addr_lo[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
        merged    = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        merged    = word;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Request-side controller for the data memory stage: one load/store per handshake,
// sub-word stores done as read-modify-write against a word-only memory.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int WORD_IDX_BITS = WORD_IDX_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        ctrl_memRead,
  output logic        ctrl_memWrite,
  output logic [31:0] mem_address,
  output logic [31:0] write_data_into_mem,
  input  logic [31:0] read_data_from_mem,
  output lsu_state_t  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid pulses once per accepted request.

  lsu_state_t  state, state_nxt;
  logic        accept;
  logic        req_err;
  logic        size_bad;
  logic        addr_hi_bad;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign dbg_state = state;
  assign accept    = req_valid && (state == IDLE);

  always_comb begin
    addr_hi_bad = (req_addr >> (WORD_IDX_BITS + 2)) != 32'd0;
    case (req_size)
      SZ_BYTE: size_bad = 1'b0;
      SZ_HALF: size_bad = req_addr[0];
      SZ_WORD: size_bad = |req_addr[1:0];
      default: size_bad = 1'b1;
    endcase
    req_err = size_bad || addr_hi_bad;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    ctrl_memRead  = 1'b0;
    ctrl_memWrite = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                             state_nxt = RESP;
          else if (req_write && req_size == SZ_WORD) state_nxt = WR_ISSUE;
          else                                     state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        ctrl_memRead = 1'b1;
        state_nxt    = RD_WAIT;
      end
      RD_WAIT:  state_nxt = write_q ? WR_ISSUE : RESP;
      WR_ISSUE: begin
        ctrl_memWrite = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_lane_align u_align (
    .word        (read_data_from_mem),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Address and write data only change outside strobe cycles, so they are stable during them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q             <= 1'b0;
      size_q              <= 2'b00;
      uns_q               <= 1'b0;
      addr_lo_q           <= 2'b00;
      wdata_q             <= 32'd0;
      resp_rdata          <= 32'd0;
      resp_error          <= 1'b0;
      mem_address         <= 32'd0;
      write_data_into_mem <= 32'd0;
    end else if (accept) begin
      write_q    <= req_write;
      size_q     <= req_size;
      uns_q      <= req_unsigned;
      addr_lo_q  <= req_addr[1:0];
      wdata_q    <= req_wdata;
      resp_rdata <= 32'd0;
      resp_error <= req_err;
      if (!req_err) begin
        mem_address <= {{(32 - WORD_IDX_BITS){1'b0}}, req_addr[WORD_IDX_BITS+1:2]};
        if (req_write && req_size == SZ_WORD) write_data_into_mem <= req_wdata;
      end
    end else if (state == RD_WAIT) begin
      if (write_q) write_data_into_mem <= merged;
      else         resp_rdata          <= load_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver pushes expected strobes/responses,
// a negedge monitor pops and compares them against a small word memory model.
module tb_load_store_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        ctrl_memRead;
  logic        ctrl_memWrite;
  logic [31:0] mem_address;
  logic [31:0] write_data_into_mem;
  logic [31:0] read_data_from_mem;
  lsu_state_t  dbg_state;

  load_store_unit #(.WORD_IDX_BITS(10)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_size            (req_size),
    .req_unsigned        (req_unsigned),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .resp_error          (resp_error),
    .ctrl_memRead        (ctrl_memRead),
    .ctrl_memWrite       (ctrl_memWrite),
    .mem_address         (mem_address),
    .write_data_into_mem (write_data_into_mem),
    .read_data_from_mem  (read_data_from_mem),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:MEM_WORDS-1];
  always @(posedge clk) begin
    if (ctrl_memWrite) mem[mem_address[9:0]] <= write_data_into_mem;
    if (ctrl_memRead)  read_data_from_mem <= mem[mem_address[9:0]];
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];     // {error, latency[3:0], rdata}
  logic [64:0] strobe_q[$];  // {is_write, word index, data}
  int          acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    logic [64:0] s;
    logic [36:0] e;
    int a;
    if (reset) begin
      if (ctrl_memRead || ctrl_memWrite) begin
        check("strobe_exclusive", {31'd0, ctrl_memRead && ctrl_memWrite}, 32'd0);
        if (strobe_q.size() == 0) fail_now("unexpected_strobe");
        else begin
          s = strobe_q.pop_front();
          check("strobe_kind", {31'd0, ctrl_memWrite}, {31'd0, s[64]});
          check("strobe_addr", mem_address, s[63:32]);
          if (s[64]) check("strobe_wdata", write_data_into_mem, s[31:0]);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("unexpected_resp");
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_rdata", resp_rdata, e[31:0]);
          check("resp_error", {31'd0, resp_error}, {31'd0, e[36]});
          check("resp_latency", cyc - a + 1, {28'd0, e[35:32]});
          check("ready_in_resp", {31'd0, req_ready}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic exp_rd(input logic [31:0] idx);
    strobe_q.push_back({1'b0, idx, 32'd0});
  endtask

  task automatic exp_wr(input logic [31:0] idx, input logic [31:0] data);
    strobe_q.push_back({1'b1, idx, data});
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic has_resp, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat, input logic hold,
                       output int acc);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (has_resp) begin
      exp_q.push_back({exp_err, exp_lat[3:0], exp_rdata});
      acc_q.push_back(acc);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || strobe_q.size() != 0); i++) @(negedge clk);
    check("drain", exp_q.size() + strobe_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    check({tag, "_memRead"}, {31'd0, ctrl_memRead}, 32'd0);
    check({tag, "_memWrite"}, {31'd0, ctrl_memWrite}, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_wdata_mem"}, write_data_into_mem, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2;
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
    mem[8] = 32'h5566_7788;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // word store then word load
    exp_wr(4, 32'hDEAD_BEEF);
    issue(1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 0, 2, 0, a1);
    wait_done();
    exp_rd(4);
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 0, 3, 0, a1);
    wait_done();
    check("rdata_hold", resp_rdata, 32'hDEAD_BEEF);

    // byte store over 0x11223344
    exp_wr(4, 32'h1122_3344);
    issue(1, SZ_WORD, 0, 32'h10, 32'h1122_3344, 1, 32'h0, 0, 2, 0, a1);
    wait_done();
    exp_rd(4);
    exp_wr(4, 32'hAA22_3344);
    issue(1, SZ_BYTE, 0, 32'h13, 32'h1234_56AA, 1, 32'h0, 0, 4, 0, a1);
    wait_done();

    // sub-word loads after the byte store
    exp_rd(4);
    issue(0, SZ_BYTE, 0, 32'h13, 32'h0, 1, 32'hFFFF_FFAA, 0, 3, 0, a1);
    wait_done();
    exp_rd(4);
    issue(0, SZ_BYTE, 1, 32'h13, 32'h0, 1, 32'h0000_00AA, 0, 3, 0, a1);
    wait_done();
    exp_rd(4);
    issue(0, SZ_HALF, 0, 32'h12, 32'h0, 1, 32'hFFFF_AA22, 0, 3, 0, a1);
    wait_done();

    // half store to the low lane, then more extractions
    exp_rd(4);
    exp_wr(4, 32'hAA22_BEEF);
    issue(1, SZ_HALF, 0, 32'h10, 32'h7777_BEEF, 1, 32'h0, 0, 4, 0, a1);
    wait_done();
    exp_rd(4);
    issue(0, SZ_HALF, 1, 32'h10, 32'h0, 1, 32'h0000_BEEF, 0, 3, 0, a1);
    wait_done();
    exp_rd(4);
    issue(0, SZ_BYTE, 0, 32'h11, 32'h0, 1, 32'hFFFF_FFBE, 0, 3, 0, a1);
    wait_done();
    exp_rd(4);
    issue(0, SZ_BYTE, 1, 32'h10, 32'h0, 1, 32'h0000_00EF, 0, 3, 0, a1);
    wait_done();

    // errors: no strobes, rdata 0, latency 1
    issue(0, SZ_HALF, 0, 32'h11, 32'h0, 1, 32'h0, 1, 1, 0, a1);
    wait_done();
    issue(1, SZ_WORD, 0, 32'h06, 32'h1234_5678, 1, 32'h0, 1, 1, 0, a1);
    wait_done();
    issue(0, SZ_WORD, 0, 32'h1000, 32'h0, 1, 32'h0, 1, 1, 0, a1);
    wait_done();
    issue(0, 2'b11, 0, 32'h0, 32'h0, 1, 32'h0, 1, 1, 0, a1);
    wait_done();
    check("error_hold", {31'd0, resp_error}, 32'd1);
    check("memory_after_errors", mem[1], 32'd0);

    // back-to-back with req_valid held high
    exp_rd(4);
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'hAA22_BEEF, 0, 3, 1, a1);
    exp_rd(4);
    issue(0, SZ_BYTE, 1, 32'h13, 32'h0, 1, 32'h0000_00AA, 0, 3, 0, a2);
    check("b2b_accept_gap", a2 - a1, 32'd4);
    wait_done();
    exp_wr(5, 32'h0BAD_F00D);
    issue(1, SZ_WORD, 0, 32'h14, 32'h0BAD_F00D, 1, 32'h0, 0, 2, 1, a1);
    issue(0, SZ_WORD, 0, 32'h15, 32'h0, 1, 32'h0, 1, 1, 0, a2);
    check("b2b_store_gap", a2 - a1, 32'd3);
    wait_done();

    // reset during RD_WAIT of a byte store
    exp_rd(8);
    issue(1, SZ_BYTE, 0, 32'h20, 32'h0000_00CC, 0, 32'h0, 0, 4, 0, a1);
    @(negedge clk);
    check("in_rd_wait", {29'd0, dbg_state}, {29'd0, RD_WAIT});
    #2 reset = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_mem_unchanged", mem[8], 32'h5566_7788);
    check("abort_idle_ready", {31'd0, req_ready}, 32'd1);
    exp_rd(8);
    issue(0, SZ_WORD, 0, 32'h20, 32'h0, 1, 32'h5566_7788, 0, 3, 0, a1);
    wait_done();

    check("final_queues", exp_q.size() + strobe_q.size() + acc_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Request-side controller for the data memory stage: accepts one load or store per handshake from execute, issues word-indexed `ctrl_memRead`/`ctrl_memWrite` accesses, and returns sign- or zero-extended load data. The data memory is word-only, so the unit handles byte and halfword stores as read-modify-write, and byte and halfword loads as lane extraction. It sits between the execute stage and the data memory block and owns all sequencing of the memory strobes.

## Interface
Parameters:
- `WORD_IDX_BITS`, default 10: width of the word index; memory holds 2**WORD_IDX_BITS words.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted on `req_valid && req_ready` at a rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as an error.
- `req_unsigned`  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  single-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned, out-of-range, or illegal-size request.
- `ctrl_memRead`  out  1  memory read strobe.
- `ctrl_memWrite`  out  1  memory write strobe.
- `mem_address`  out  32  word index, `{zeros, addr[WORD_IDX_BITS+1:2]}`.
- `write_data_into_mem`  out  32  full word to write.
- `read_data_from_mem`  in  32  memory read data, valid the cycle after the read strobe.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE behaviour:
  - `req_ready` = 1 only in IDLE.
  - On accept, register `req_write`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata`, then compute the next state.
- Error check at accept. The request is an error if any of these holds:
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - `req_size`=11;
  - `addr[31:WORD_IDX_BITS+2]`≠0.
- On error: go to RESP with `resp_error`=1 and `resp_rdata`=0. No memory strobe is issued.
- Load: IDLE → RD_ISSUE → RD_WAIT → RESP.
  - In RD_WAIT, extract the lane from `read_data_from_mem` and extend it, then register the result into `resp_rdata`.
- Word store: IDLE → WR_ISSUE → RESP.
- Byte/half store: IDLE → RD_ISSUE → RD_WAIT → WR_ISSUE → RESP.
  - In RD_WAIT, replace the addressed lane of the read word with the low bits of the stored data.
  - Register the merged word into `write_data_into_mem`.
- Lane mapping is little-endian:
  - byte k = bits [8k+7:8k], with k = `addr[1:0]`;
  - half h = bits [16h+15:16h], with h = `addr[1]`.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Strobes are Moore outputs of the registered state:
  - `ctrl_memRead`=1 only in RD_ISSUE;
  - `ctrl_memWrite`=1 only in WR_ISSUE;
  - they are never both 1.
- `mem_address` and `write_data_into_mem` are stable for the whole strobe cycle and hold their last value otherwise.
- `resp_rdata` and `resp_error` hold until the next accept.

## Timing
- Accept at edge 0. Latency to `resp_valid`:
  - load: cycle 3;
  - word store: cycle 2;
  - byte/half store: cycle 4;
  - error: cycle 1.
- Back-to-back requests: the next accept happens earliest at the edge that ends RESP+1, i.e. in the first IDLE cycle after RESP. No pipelining.
- `req_*` inputs are don't-care outside the accept edge.
- Reset asserted (low), at any time:
  - state goes to IDLE immediately and all strobes drop to 0 asynchronously;
  - a byte/half store aborted before WR_ISSUE leaves memory unmodified;
  - no `resp_valid` is produced for the aborted request.
- Reset values: `req_ready`=1; all other outputs (`resp_valid`, `resp_rdata`, `resp_error`, `ctrl_memRead`, `ctrl_memWrite`, `mem_address`, `write_data_into_mem`) are 0.

## Structure
- Shared package `mem_pkg` holds:
  - `mem_size_t` enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - `lsu_state_t` enum;
  - `MEM_WORDS` constant.
- Combinational sub-module `mem_lane_align` does the lane work, used for both loads and stores:
  - extract + extend for loads;
  - merge for stores;
  - inputs: word, addr[1:0], size, unsigned, wdata.
- The top level holds the FSM and the registers.

## Test plan
- Word store: addr 0x10, data 0xDEADBEEF.
  - Required: `ctrl_memWrite` pulse with `mem_address`=4 and data 0xDEADBEEF.
  - Then a word load from 0x10 returns 0xDEADBEEF with `resp_valid` at cycle 3.
- Byte store: 0xAA to 0x13 over stored word 0x11223344.
  - Required: read of index 4, then write of 0xAA223344; `resp_valid` at cycle 4.
- Loads from 0x13 after the byte store:
  - signed byte returns 0xFFFFFFAA;
  - unsigned byte returns 0x000000AA;
  - signed half from 0x12 returns 0xFFFFAA22.
- Errors produce no strobes, and `resp_error`=1, `resp_rdata`=0 at cycle 1, for each of:
  - half load at 0x11;
  - word store at 0x06;
  - addr 0x1000 (out of range for 10 bits);
  - size 11.
- Reset pulsed during RD_WAIT of a byte store:
  - no `ctrl_memWrite` is issued;
  - all outputs return to reset values;
  - `req_ready`=1;
  - memory word is unchanged.
- `req_valid` held high continuously across two requests:
  - the second request is accepted only in IDLE;
  - `req_ready` is low from edge 0 through RESP.
